// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, centre-sampling FSM, LSB-first byte
// assembly, one-cycle valid / framing_error strobes.
module uart_rx #(
  parameter int BAUD_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int CW   = $clog2(BAUD_TICKS + 1);
  localparam int HALF = BAUD_TICKS / 2;
  // The detection cycle in IDLE counts as the first half-bit tick, so the
  // start sample lands exactly HALF cycles after rx_s is first seen low.
  localparam logic [CW-1:0] HALF_LD = CW'(HALF - 1);
  localparam logic [CW-1:0] BAUD_LD = CW'(BAUD_TICKS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            rx_s_q, rx_s_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            busy_q, busy_d;
  logic            sample;

  assign sample = (cnt_q == '0);

  always_comb begin
    sync1_d = rx;
    rx_s_d  = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          cnt_d   = HALF_LD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (sample) begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = BAUD_LD;
            idx_d   = 3'd0;
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (sample) begin
          shreg_d = {rx_s_q, shreg_q[7:1]};
          cnt_d   = BAUD_LD;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STOP: begin
        if (sample) begin
          cnt_d = BAUD_LD;
          if (rx_s_q) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_BREAK: begin
        // A line stuck low must go high before a new frame can start.
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shreg_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      rx_s_q  <= rx_s_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign data_out      = data_q;
  assign valid         = valid_q;
  assign framing_error = ferr_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a frame-level model predicts the cycle and
// value of every strobe from when each start bit was put on the line.
module tb_uart_rx;
  localparam int BT  = 10;
  localparam int BIT = BT + 1;
  // rx edge -> T0 is 2 cycles, T0 -> strobe is HALF + 9*BIT + 1 = 105.
  localparam int LAT = 2 + BT / 2 + 9 * BIT + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       valid, framing_error, busy;

  uart_rx #(.BAUD_TICKS(BT)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .data_out(data_out), .valid(valid),
    .framing_error(framing_error), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [7:0] d;
    bit         ferr;
  } ev_t;

  ev_t        exp_q[$];
  bit         busy_exp[int];
  logic [7:0] model_data = 8'h00;
  int         vcyc_q[$];
  int         nvalid = 0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, req);
    end
  endtask

  function automatic int last_v();
    return (vcyc_q.size() > 0) ? vcyc_q[vcyc_q.size()-1] : -1;
  endfunction

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bitp(input logic v);
    rx = v;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; cyc is then the cycle in which rx falls.
  task automatic send(input logic [7:0] b, input bit good, input int hold);
    int c;
    c = cyc;
    exp_q.push_back(ev_t'{at: c + LAT, d: b, ferr: !good});
    busy_exp[c + 3] = 1'b1;
    if (good) begin
      busy_exp[c + 2]       = 1'b0;
      busy_exp[c + LAT - 1] = 1'b1;
      busy_exp[c + LAT]     = 1'b0;
    end else begin
      busy_exp[c + LAT] = 1'b1;
    end
    bitp(1'b0);
    for (int i = 0; i < 8; i++) bitp(b[i]);
    if (good) begin
      bitp(1'b1);
    end else begin
      bitp(1'b0);
      rx = 1'b0;
      repeat (hold) @(posedge clk);
      #1;
    end
  endtask

  // Compare process: every cycle out of reset, strobes and data_out vs model.
  initial begin : compare
    bit  ev, ef;
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ev = 1'b0;
        ef = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
          e = exp_q.pop_front();
          if (e.ferr) ef = 1'b1;
          else begin
            ev = 1'b1;
            model_data = e.d;
          end
        end
        chk("valid", valid, ev);
        chk("framing_error", framing_error, ef);
        chk("data_out", data_out, model_data);
        if (busy_exp.exists(cyc)) begin
          chk("busy", busy, busy_exp[cyc]);
          busy_exp.delete(cyc);
        end
        if (valid) begin
          nvalid++;
          vcyc_q.push_back(cyc);
        end
      end
    end
  end

  initial begin : stim
    int c0, n0;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_framing_error", framing_error, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    idle(10);

    // single byte, latency pinned by a literal
    c0 = cyc;
    send(8'hA5, 1'b1, 0);
    idle(20);
    chk("a5_latency", last_v() - c0, 107);
    chk("a5_data", data_out, 8'hA5);

    // back-to-back frames
    n0 = vcyc_q.size();
    send(8'h00, 1'b1, 0);
    send(8'hFF, 1'b1, 0);
    send(8'h81, 1'b1, 0);
    idle(20);
    chk("b2b_count", vcyc_q.size() - n0, 3);
    if (vcyc_q.size() - n0 == 3) begin
      chk("b2b_spacing1", vcyc_q[n0+1] - vcyc_q[n0], 110);
      chk("b2b_spacing2", vcyc_q[n0+2] - vcyc_q[n0+1], 110);
    end
    chk("b2b_last", data_out, 8'h81);

    // false start: 3-cycle glitch
    c0 = cyc;
    busy_exp[c0 + 3] = 1'b1;
    busy_exp[c0 + 8] = 1'b0;
    n0 = nvalid;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(20);
    chk("glitch_no_valid", nvalid - n0, 0);
    send(8'h12, 1'b1, 0);
    idle(20);
    chk("after_glitch", data_out, 8'h12);

    // framing error, line held low afterwards
    n0 = nvalid;
    send(8'h7E, 1'b0, 50);
    idle(20);
    chk("ferr_keeps_data", data_out, 8'h12);
    chk("ferr_no_valid", nvalid - n0, 0);
    send(8'h99, 1'b1, 0);
    idle(20);
    chk("after_ferr", data_out, 8'h99);

    // reset in the middle of a 0x55 frame
    bitp(1'b0);
    bitp(1'b1);
    bitp(1'b0);
    bitp(1'b1);
    rst = 1'b1;
    exp_q.delete();
    busy_exp.delete();
    model_data = 8'h00;
    #1;
    chk("midrst_data_out", data_out, 8'h00);
    chk("midrst_valid", valid, 1'b0);
    chk("midrst_framing_error", framing_error, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(5);
    n0 = nvalid;
    send(8'h3C, 1'b1, 0);
    idle(20);
    chk("post_rst_count", nvalid - n0, 1);
    chk("post_rst_data", data_out, 8'h3C);

    // loopback-style stream of random bytes
    n0 = nvalid;
    for (int i = 0; i < 256; i++) send(8'($urandom_range(0, 255)), 1'b1, 0);
    idle(20);
    chk("stream_count", nvalid - n0, 256);
    chk("pending_events", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
